// File: rtl/cpu_trace_checker.sv
// cpu_trace_checker
// Watches a CPU's pc/inst/result buses during a checking run and compares the
// result presented at each retire (pc change) against a preloaded table of
// expected values. A run ends in DONE when pc stays unchanged for HALT_LIMIT
// cycles, or in FAIL on the first mismatch, whose details are captured.
//
// Ports
//   clk          rising-edge clock
//   resetn       synchronous reset, active high (1 = reset)
//   start        one-cycle pulse that arms a run (ignored while busy)
//   pc_i         CPU program counter
//   inst_i       CPU instruction (captured on mismatch, never checked)
//   result_i     CPU result bus
//   exp_we       expected-table write strobe (ignored while busy)
//   exp_addr     expected-table write index
//   exp_data     expected-table write data
//   busy         run in progress
//   done         run ended by halt with no mismatch
//   fail         run ended by mismatch
//   retired_cnt  retire events in the current run
//   cycle_cnt    cycles spent running
//   mism_idx     retire index of the first mismatch
//   mism_got     result_i at the first mismatch
//   mism_inst    inst_i at the first mismatch
module cpu_trace_checker #(
   parameter int unsigned DW         = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned HALT_LIMIT = 8,
   parameter int unsigned CW         = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     start,
   input  logic [DW-1:0]            pc_i,
   input  logic [DW-1:0]            inst_i,
   input  logic [DW-1:0]            result_i,
   input  logic                     exp_we,
   input  logic [$clog2(DEPTH)-1:0] exp_addr,
   input  logic [DW-1:0]            exp_data,
   output logic                     busy,
   output logic                     done,
   output logic                     fail,
   output logic [CW-1:0]            retired_cnt,
   output logic [CW-1:0]            cycle_cnt,
   output logic [CW-1:0]            mism_idx,
   output logic [DW-1:0]            mism_got,
   output logic [DW-1:0]            mism_inst
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned SW = $clog2(HALT_LIMIT);

   typedef enum logic [1:0] {StIdle, StRun, StDone, StFail} state_e;

   state_e            state_q, state_d;
   logic [DW-1:0]     pc_q, pc_d;
   logic [SW-1:0]     stall_q, stall_d;
   logic [CW-1:0]     retired_q, retired_d;
   logic [CW-1:0]     cycle_q, cycle_d;
   logic [CW-1:0]     mism_idx_q, mism_idx_d;
   logic [DW-1:0]     mism_got_q, mism_got_d;
   logic [DW-1:0]     mism_inst_q, mism_inst_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              fail_q, fail_d;

   // Table data has no reset; only the valid bits are cleared.
   logic [DW-1:0]     exp_mem [DEPTH];

   logic              exp_wr;
   logic [AW-1:0]     idx;
   logic              retire;
   logic              checked;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      stall_d     = stall_q;
      retired_d   = retired_q;
      cycle_d     = cycle_q;
      mism_idx_d  = mism_idx_q;
      mism_got_d  = mism_got_q;
      mism_inst_d = mism_inst_q;
      valid_d     = valid_q;

      exp_wr  = exp_we && (state_q != StRun);
      idx     = retired_q[AW-1:0];
      retire  = (state_q == StRun) && (pc_i != pc_q);
      // Only the first DEPTH retires have table entries; later ones must not alias.
      checked = (retired_q < CW'(DEPTH)) && valid_q[idx];

      if (exp_wr) begin
         valid_d[exp_addr] = 1'b1;
      end

      case (state_q)
         StRun: begin
            cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + CW'(1);
            pc_d    = pc_i;
            if (retire) begin
               retired_d = (retired_q == '1) ? retired_q : retired_q + CW'(1);
               stall_d   = '0;
               if (checked && (result_i != exp_mem[idx])) begin
                  mism_idx_d  = retired_q;
                  mism_got_d  = result_i;
                  mism_inst_d = inst_i;
                  state_d     = StFail;
               end
            end else if (stall_q == SW'(HALT_LIMIT - 1)) begin
               // This is the HALT_LIMIT-th consecutive unchanged cycle.
               state_d = StDone;
            end else begin
               stall_d = stall_q + SW'(1);
            end
         end
         default: begin
            if (start) begin
               state_d     = StRun;
               pc_d        = pc_i;
               stall_d     = '0;
               retired_d   = '0;
               cycle_d     = '0;
               mism_idx_d  = '0;
               mism_got_d  = '0;
               mism_inst_d = '0;
            end
         end
      endcase

      busy_d = (state_d == StRun);
      done_d = (state_d == StDone);
      fail_d = (state_d == StFail);
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q     <= StIdle;
         pc_q        <= '0;
         stall_q     <= '0;
         retired_q   <= '0;
         cycle_q     <= '0;
         mism_idx_q  <= '0;
         mism_got_q  <= '0;
         mism_inst_q <= '0;
         valid_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         stall_q     <= stall_d;
         retired_q   <= retired_d;
         cycle_q     <= cycle_d;
         mism_idx_q  <= mism_idx_d;
         mism_got_q  <= mism_got_d;
         mism_inst_q <= mism_inst_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn && exp_wr) begin
         exp_mem[exp_addr] <= exp_data;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign fail        = fail_q;
   assign retired_cnt = retired_q;
   assign cycle_cnt   = cycle_q;
   assign mism_idx    = mism_idx_q;
   assign mism_got    = mism_got_q;
   assign mism_inst   = mism_inst_q;

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Bench for cpu_trace_checker: directed scenarios plus randomized runs, each
// checked against a run-level reference model of the checker's rules.
module tb_cpu_trace_checker;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned HL    = 8;
   localparam int unsigned CW    = 32;
   localparam int          MAXC  = 128;

   logic          clk = 1'b0;
   logic          resetn, start, exp_we;
   logic [DW-1:0] pc_i, inst_i, result_i, exp_data;
   logic [3:0]    exp_addr;
   logic          busy, done, fail;
   logic [CW-1:0] retired_cnt, cycle_cnt, mism_idx;
   logic [DW-1:0] mism_got, mism_inst;

   always #5 clk = ~clk;

   cpu_trace_checker #(.DW(DW), .DEPTH(DEPTH), .HALT_LIMIT(HL), .CW(CW)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .pc_i       (pc_i),
      .inst_i     (inst_i),
      .result_i   (result_i),
      .exp_we     (exp_we),
      .exp_addr   (exp_addr),
      .exp_data   (exp_data),
      .busy       (busy),
      .done       (done),
      .fail       (fail),
      .retired_cnt(retired_cnt),
      .cycle_cnt  (cycle_cnt),
      .mism_idx   (mism_idx),
      .mism_got   (mism_got),
      .mism_inst  (mism_inst)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: expected table as seen by the checker.
   logic [DW-1:0] exp_m [DEPTH];
   bit            valid_m [DEPTH];
   bit            mdl_running = 1'b0;

   // Per-cycle stimulus of one run (cycle c is the c-th cycle after start).
   logic [DW-1:0] run_pc0;
   logic [DW-1:0] s_pc [MAXC];
   logic [DW-1:0] s_res [MAXC];
   logic [DW-1:0] s_inst [MAXC];
   bit            s_we [MAXC];
   logic [3:0]    s_wa [MAXC];
   logic [DW-1:0] s_wd [MAXC];
   int            s_n;

   // Model expectations for the run.
   bit            m_done, m_fail;
   int            m_end, dut_end;
   logic [CW-1:0] m_cnt, m_cyc, m_idx;
   logic [DW-1:0] m_got, m_inst;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_seq();
      for (int i = 0; i < MAXC; i++) begin
         s_we[i] = 1'b0;
         s_wa[i] = '0;
         s_wd[i] = '0;
      end
      s_n = 0;
   endtask

   task automatic push(input logic [DW-1:0] pc, input logic [DW-1:0] res);
      s_pc[s_n]   = pc;
      s_res[s_n]  = res;
      s_inst[s_n] = $urandom;
      s_n++;
   endtask

   // Walk the run: a retire is a pc change; the first DEPTH retires are
   // checked against valid table entries; HL unchanged cycles in a row halt.
   task automatic model_run();
      logic [DW-1:0] prev;
      int            stalls;
      int            k;
      prev   = run_pc0;
      stalls = 0;
      m_done = 1'b0; m_fail = 1'b0; m_end = -1;
      m_cnt  = '0; m_cyc = '0; m_idx = '0; m_got = '0; m_inst = '0;
      for (int c = 0; c < s_n; c++) begin
         m_cyc++;
         if (s_pc[c] != prev) begin
            k = int'(m_cnt);
            m_cnt++;
            stalls = 0;
            if (k < DEPTH && valid_m[k] && s_res[c] != exp_m[k]) begin
               m_fail = 1'b1; m_idx = CW'(k); m_got = s_res[c]; m_inst = s_inst[c];
               m_end = c;
               break;
            end
         end else begin
            stalls++;
            if (stalls == HL) begin
               m_done = 1'b1;
               m_end  = c;
               break;
            end
         end
         prev = s_pc[c];
      end
   endtask

   task automatic do_run();
      model_run();
      pc_i  = run_pc0;
      start = 1'b1;
      step();
      start   = 1'b0;
      dut_end = -1;
      for (int c = 0; c < s_n; c++) begin
         pc_i = s_pc[c]; result_i = s_res[c]; inst_i = s_inst[c];
         exp_we = s_we[c]; exp_addr = s_wa[c]; exp_data = s_wd[c];
         step();
         exp_we = 1'b0;
         if (!busy) begin
            dut_end = c;
            break;
         end
      end
      mdl_running = (m_end < 0);
   endtask

   task automatic load(input int a, input logic [DW-1:0] d);
      exp_we = 1'b1; exp_addr = 4'(a); exp_data = d;
      step();
      exp_we = 1'b0;
      if (!mdl_running) begin
         exp_m[a]   = d;
         valid_m[a] = 1'b1;
      end
   endtask

   task automatic do_reset(input bit noise);
      resetn = 1'b1;
      if (noise) begin
         start = 1'b1; exp_we = 1'b1; exp_addr = 4'd2; exp_data = 32'd1234;
      end
      step();
      resetn = 1'b0; start = 1'b0; exp_we = 1'b0;
      for (int i = 0; i < DEPTH; i++) valid_m[i] = 1'b0;
      mdl_running = 1'b0;
   endtask

   task automatic test_reset();
      step();
      step();
      n_cmp++; if ({busy, done, fail, retired_cnt, cycle_cnt, mism_idx, mism_got, mism_inst} !== '0) begin
         n_err++; $display("FAIL reset_outputs: got busy=%0b done=%0b fail=%0b ret=%0d cyc=%0d want all 0",
                           busy, done, fail, retired_cnt, cycle_cnt);
      end
      resetn = 1'b0;
      step();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %0b want 0", busy); end
   endtask

   task automatic test_pass();
      load(0, 32'd5); load(1, 32'd7); load(2, 32'd9);
      clear_seq(); run_pc0 = 32'd0;
      push(32'd4, 32'd5); push(32'd8, 32'd7); push(32'd12, 32'd9);
      for (int i = 0; i < 10; i++) push(32'd12, $urandom);
      do_run();
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL pass_done: got %0b want 1", done); end
      n_cmp++; if (fail !== 1'b0) begin n_err++; $display("FAIL pass_fail: got %0b want 0", fail); end
      n_cmp++; if (retired_cnt !== 32'd3) begin n_err++; $display("FAIL pass_retired: got %0d want 3", retired_cnt); end
      n_cmp++; if (cycle_cnt !== m_cyc) begin n_err++; $display("FAIL pass_cycles: got %0d want %0d", cycle_cnt, m_cyc); end
      n_cmp++; if (dut_end !== m_end) begin n_err++; $display("FAIL pass_timing: ended at %0d want %0d", dut_end, m_end); end
   endtask

   task automatic test_mismatch();
      clear_seq(); run_pc0 = 32'd0;
      push(32'd4, 32'd5); push(32'd8, 32'd8); push(32'd12, 32'd9);
      for (int i = 0; i < 10; i++) push(32'd12, 32'd0);
      do_run();
      n_cmp++; if (fail !== 1'b1) begin n_err++; $display("FAIL mism_fail: got %0b want 1", fail); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mism_busy: got %0b want 0", busy); end
      n_cmp++; if (mism_idx !== 32'd1) begin n_err++; $display("FAIL mism_idx: got %0d want 1", mism_idx); end
      n_cmp++; if (mism_got !== 32'd8) begin n_err++; $display("FAIL mism_got: got %0d want 8", mism_got); end
      n_cmp++; if (mism_inst !== s_inst[1]) begin n_err++; $display("FAIL mism_inst: got %h want %h", mism_inst, s_inst[1]); end
      n_cmp++; if (dut_end !== 1) begin n_err++; $display("FAIL mism_timing: ended at %0d want 1", dut_end); end
   endtask

   task automatic test_unchecked();
      do_reset(1'b0);
      clear_seq(); run_pc0 = 32'd0;
      for (int i = 0; i < 20; i++) push(32'(4 * (i + 1)), $urandom);
      for (int i = 0; i < 10; i++) push(32'd80, $urandom);
      do_run();
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL unchk_done: got %0b want 1", done); end
      n_cmp++; if (retired_cnt !== 32'd20) begin n_err++; $display("FAIL unchk_retired: got %0d want 20", retired_cnt); end
      n_cmp++; if (dut_end !== 27) begin n_err++; $display("FAIL unchk_timing: ended at %0d want 27", dut_end); end
   endtask

   task automatic test_coincide();
      load(0, 32'd5); load(1, 32'd7);
      clear_seq(); run_pc0 = 32'd0;
      push(32'd4, 32'd5);
      for (int i = 0; i < HL - 1; i++) push(32'd4, 32'd0);
      push(32'd8, 32'd99);
      for (int i = 0; i < 10; i++) push(32'd8, 32'd0);
      do_run();
      n_cmp++; if (fail !== 1'b1) begin n_err++; $display("FAIL coin_fail: got %0b want 1", fail); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL coin_done: got %0b want 0", done); end
      n_cmp++; if (dut_end !== m_end) begin n_err++; $display("FAIL coin_timing: ended at %0d want %0d", dut_end, m_end); end
      pc_i = 32'd0; start = 1'b1;
      step();
      start = 1'b0; mdl_running = 1'b1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL coin_restart_busy: got %0b want 1", busy); end
      n_cmp++; if ({retired_cnt, cycle_cnt, mism_idx, mism_got} !== '0) begin
         n_err++; $display("FAIL coin_restart_clear: got ret=%0d cyc=%0d idx=%0d got=%0d want 0",
                           retired_cnt, cycle_cnt, mism_idx, mism_got);
      end
      for (int i = 0; i < HL; i++) step();
      mdl_running = 1'b0;
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL coin_rerun_done: got %0b want 1", done); end
   endtask

   task automatic test_reset_mid_run();
      clear_seq(); run_pc0 = 32'd0;
      push(32'd4, 32'd5); push(32'd8, 32'd7);
      push(32'd12, 32'd1); push(32'd16, 32'd2); push(32'd20, 32'd3);
      for (int i = 0; i < 3; i++) push(32'd20, 32'd0);
      do_run();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy: got %0b want 1", busy); end
      n_cmp++; if (retired_cnt !== 32'd5) begin n_err++; $display("FAIL midrst_retired: got %0d want 5", retired_cnt); end
      do_reset(1'b1);
      n_cmp++; if ({busy, done, fail, retired_cnt, cycle_cnt, mism_idx, mism_got, mism_inst} !== '0) begin
         n_err++; $display("FAIL midrst_outputs: got busy=%0b done=%0b fail=%0b ret=%0d cyc=%0d want all 0",
                           busy, done, fail, retired_cnt, cycle_cnt);
      end
      step();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_start_ignored: got %0b want 0", busy); end
      clear_seq(); run_pc0 = 32'd0;
      push(32'd4, 32'd5); push(32'd8, 32'd8); push(32'd12, 32'd0);
      for (int i = 0; i < 10; i++) push(32'd12, 32'd0);
      do_run();
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL midrst_rerun_done: got %0b want 1", done); end
      n_cmp++; if (fail !== 1'b0) begin n_err++; $display("FAIL midrst_rerun_fail: got %0b want 0", fail); end
   endtask

   task automatic test_we_in_run();
      load(0, 32'd5);
      clear_seq(); run_pc0 = 32'd0;
      push(32'd0, 32'd0);
      s_we[0] = 1'b1; s_wa[0] = 4'd0; s_wd[0] = 32'd6;
      push(32'd4, 32'd5);
      for (int i = 0; i < 10; i++) push(32'd4, 32'd0);
      do_run();
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL werun_done: got %0b want 1", done); end
      n_cmp++; if (fail !== 1'b0) begin n_err++; $display("FAIL werun_fail: got %0b want 0", fail); end
      load(0, 32'd6);
      clear_seq(); run_pc0 = 32'd0;
      push(32'd4, 32'd5);
      for (int i = 0; i < 10; i++) push(32'd4, 32'd0);
      do_run();
      n_cmp++; if (fail !== 1'b1) begin n_err++; $display("FAIL weafter_fail: got %0b want 1", fail); end
      n_cmp++; if (mism_got !== 32'd5) begin n_err++; $display("FAIL weafter_got: got %0d want 5", mism_got); end
   endtask

   task automatic test_random();
      logic [DW-1:0] lp;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 5) == 0) do_reset(1'b0);
         for (int j = $urandom_range(0, 5); j > 0; j--) load(int'($urandom_range(0, DEPTH - 1)), 32'($urandom_range(0, 3)));
         clear_seq();
         run_pc0 = 32'($urandom_range(0, 3));
         lp = run_pc0;
         for (int c = $urandom_range(5, 60); c > 0; c--) begin
            if ($urandom_range(0, 7) == 0) begin
               for (int h = 0; h < int'(HL) - 1; h++) push(lp, 32'($urandom_range(0, 3)));
            end else begin
               lp = 32'($urandom_range(0, 3));
               push(lp, 32'($urandom_range(0, 3)));
            end
         end
         for (int h = 0; h < int'(HL); h++) push(lp, 32'($urandom_range(0, 3)));
         do_run();
         n_cmp++; if (done !== m_done) begin n_err++; $display("FAIL rnd%0d_done: got %0b want %0b", it, done, m_done); end
         n_cmp++; if (fail !== m_fail) begin n_err++; $display("FAIL rnd%0d_fail: got %0b want %0b", it, fail, m_fail); end
         n_cmp++; if (dut_end !== m_end) begin n_err++; $display("FAIL rnd%0d_timing: ended at %0d want %0d", it, dut_end, m_end); end
         n_cmp++; if (retired_cnt !== m_cnt) begin n_err++; $display("FAIL rnd%0d_retired: got %0d want %0d", it, retired_cnt, m_cnt); end
         n_cmp++; if (cycle_cnt !== m_cyc) begin n_err++; $display("FAIL rnd%0d_cycles: got %0d want %0d", it, cycle_cnt, m_cyc); end
         n_cmp++; if (mism_idx !== m_idx) begin n_err++; $display("FAIL rnd%0d_idx: got %0d want %0d", it, mism_idx, m_idx); end
         n_cmp++; if (mism_got !== m_got) begin n_err++; $display("FAIL rnd%0d_got: got %0d want %0d", it, mism_got, m_got); end
         n_cmp++; if (mism_inst !== m_inst) begin n_err++; $display("FAIL rnd%0d_inst: got %h want %h", it, mism_inst, m_inst); end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      resetn = 1'b1; start = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      pc_i = '0; inst_i = '0; result_i = '0;
      for (int i = 0; i < DEPTH; i++) begin
         exp_m[i]   = '0;
         valid_m[i] = 1'b0;
      end
      test_reset();
      test_pass();
      test_mismatch();
      test_unchecked();
      test_coincide();
      test_reset_mid_run();
      test_we_in_run();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
